// File: rtl/otter_dmem_arb_pkg.sv
// rtl/otter_dmem_arb_pkg.sv - shared types and constants for the OTTER data-port arbiter
//
// Contents:
//   arb_state_t  : arbiter FSM states (IDLE, RD_RESP)
//   req_id_t     : requester identity (REQ_M0 = CPU, REQ_M1 = loader/DMA)
//   SZ_*         : MEM_SIZE encodings
//   IO_BASE      : first address of the memory-mapped IO window
//   size_legal() : true for the three defined access sizes

package otter_dmem_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_RESP = 1'b1
    } arb_state_t;

    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_id_t;

    localparam logic [1:0]  SZ_BYTE = 2'd0;
    localparam logic [1:0]  SZ_HALF = 2'd1;
    localparam logic [1:0]  SZ_WORD = 2'd2;

    localparam logic [31:0] IO_BASE = 32'h1100_0000;

    function automatic logic size_legal(input logic [1:0] sz);
        return (sz == SZ_BYTE) || (sz == SZ_HALF) || (sz == SZ_WORD);
    endfunction

endpackage

// File: rtl/otter_arb2_picker.sv
// rtl/otter_arb2_picker.sv - two-way winner selection with round-robin or starvation-guarded priority
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   req[1:0]      : raw requests, bit 0 = M0, bit 1 = M1
//   grant_accept  : the current winner is actually granted this cycle
//   winner        : selected requester (combinational)
//   winner_valid  : at least one request is present
//
// FAIR = 1 : ties go to the requester that was not granted last.
// FAIR = 0 : M0 wins ties until M1 has waited STARVE_LIMIT cycles.

module otter_arb2_picker
    import otter_dmem_arb_pkg::*;
#(
    parameter bit FAIR         = 1'b1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_accept,
    output req_id_t    winner,
    output logic       winner_valid
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    req_id_t       last_grant;
    logic [CW-1:0] starve_cnt;
    logic          starved;
    logic          m1_granted;

    assign starved    = (starve_cnt == CW'(STARVE_LIMIT));
    assign m1_granted = grant_accept && (winner == REQ_M1);

    always_comb begin
        winner       = REQ_M0;
        winner_valid = |req;
        if (req == 2'b10) begin
            winner = REQ_M1;
        end else if (req == 2'b11) begin
            if (FAIR) begin
                winner = (last_grant == REQ_M0) ? REQ_M1 : REQ_M0;
            end else begin
                winner = starved ? REQ_M1 : REQ_M0;
            end
        end
    end

    // The wait counter keeps running while the arbiter is busy returning
    // read data, so a waiting M1 also ages through response cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= REQ_M1;
            starve_cnt <= '0;
        end else begin
            if (grant_accept) begin
                last_grant <= winner;
            end
            if (!req[1] || m1_granted) begin
                starve_cnt <= '0;
            end else if (!starved) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/otter_dmem_arbiter.sv
// rtl/otter_dmem_arbiter.sv - shares the OTTER memory data port between the CPU and a loader/DMA master
//
// Ports:
//   CLK, RST                          : clock, synchronous active-high reset
//   M0_* / M1_*                       : requester interfaces (REQ/ADDR/DIN/WE/SIZE/SIGN in,
//                                       GNT/RVALID/DOUT out); GNT is combinational
//   MEM_ADDR2/DIN2/WRITE2/READ2/SIZE/SIGN : drive the memory data port
//   MEM_DOUT2                         : sliced read data from the data port
//
// Stores complete in the grant cycle. Loads take the grant cycle plus one
// response cycle, during which the captured address/size/sign are replayed
// because the port slices its read data from those live inputs.

module otter_dmem_arbiter
    import otter_dmem_arb_pkg::*;
#(
    parameter bit FAIR         = 1'b1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        M0_REQ,
    input  logic [31:0] M0_ADDR,
    input  logic [31:0] M0_DIN,
    input  logic        M0_WE,
    input  logic [1:0]  M0_SIZE,
    input  logic        M0_SIGN,
    output logic        M0_GNT,
    output logic        M0_RVALID,
    output logic [31:0] M0_DOUT,

    input  logic        M1_REQ,
    input  logic [31:0] M1_ADDR,
    input  logic [31:0] M1_DIN,
    input  logic        M1_WE,
    input  logic [1:0]  M1_SIZE,
    input  logic        M1_SIGN,
    output logic        M1_GNT,
    output logic        M1_RVALID,
    output logic [31:0] M1_DOUT,

    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic        MEM_WRITE2,
    output logic        MEM_READ2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2
);

    arb_state_t  state;
    req_id_t     rd_owner_q;
    logic [31:0] rd_addr_q;
    logic [1:0]  rd_size_q;
    logic        rd_sign_q;

    req_id_t     winner;
    logic        winner_valid;
    logic        grant;

    logic [31:0] win_addr;
    logic [31:0] win_din;
    logic        win_we;
    logic [1:0]  win_size;
    logic        win_sign;

    // Reset outranks every request, including one already waiting.
    assign grant = !RST && (state == IDLE) && winner_valid;

    otter_arb2_picker #(
        .FAIR         (FAIR),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_picker (
        .clk          (CLK),
        .rst          (RST),
        .req          ({M1_REQ, M0_REQ}),
        .grant_accept (grant),
        .winner       (winner),
        .winner_valid (winner_valid)
    );

    always_comb begin
        if (winner == REQ_M1) begin
            win_addr = M1_ADDR;
            win_din  = M1_DIN;
            win_we   = M1_WE;
            win_size = M1_SIZE;
            win_sign = M1_SIGN;
        end else begin
            win_addr = M0_ADDR;
            win_din  = M0_DIN;
            win_we   = M0_WE;
            win_size = M0_SIZE;
            win_sign = M0_SIGN;
        end
    end

    always_comb begin
        M0_GNT     = 1'b0;
        M1_GNT     = 1'b0;
        M0_RVALID  = 1'b0;
        M1_RVALID  = 1'b0;
        M0_DOUT    = '0;
        M1_DOUT    = '0;
        MEM_ADDR2  = '0;
        MEM_DIN2   = '0;
        MEM_WRITE2 = 1'b0;
        MEM_READ2  = 1'b0;
        MEM_SIZE   = '0;
        MEM_SIGN   = 1'b0;
        if (!RST) begin
            if (state == IDLE) begin
                if (winner_valid) begin
                    M0_GNT     = (winner == REQ_M0);
                    M1_GNT     = (winner == REQ_M1);
                    MEM_ADDR2  = win_addr;
                    MEM_DIN2   = win_din;
                    MEM_SIZE   = win_size;
                    MEM_SIGN   = win_sign;
                    MEM_WRITE2 = win_we;
                    MEM_READ2  = !win_we;
                end
            end else begin
                // Response cycle: hold the load's address/size/sign so the
                // port's combinational slicer produces the owner's data.
                MEM_ADDR2 = rd_addr_q;
                MEM_SIZE  = rd_size_q;
                MEM_SIGN  = rd_sign_q;
                if (rd_owner_q == REQ_M0) begin
                    M0_RVALID = 1'b1;
                    M0_DOUT   = MEM_DOUT2;
                end else begin
                    M1_RVALID = 1'b1;
                    M1_DOUT   = MEM_DOUT2;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            rd_owner_q <= REQ_M0;
            rd_addr_q  <= '0;
            rd_size_q  <= '0;
            rd_sign_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant && !win_we) begin
                        state      <= RD_RESP;
                        rd_owner_q <= winner;
                        rd_addr_q  <= win_addr;
                        rd_size_q  <= win_size;
                        rd_sign_q  <= win_sign;
                    end
                end
                RD_RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Requester handshake rules: a pending request is neither withdrawn nor
    // altered until it is granted.
    a_m0_req_held: assert property (@(posedge CLK) disable iff (RST)
        (M0_REQ && !M0_GNT) |=> M0_REQ);
    a_m0_fields_stable: assert property (@(posedge CLK) disable iff (RST)
        (M0_REQ && !M0_GNT) |=> $stable({M0_ADDR, M0_DIN, M0_WE, M0_SIZE, M0_SIGN}));
    a_m0_size: assert property (@(posedge CLK) disable iff (RST)
        M0_REQ |-> size_legal(M0_SIZE));

    a_m1_req_held: assert property (@(posedge CLK) disable iff (RST)
        (M1_REQ && !M1_GNT) |=> M1_REQ);
    a_m1_fields_stable: assert property (@(posedge CLK) disable iff (RST)
        (M1_REQ && !M1_GNT) |=> $stable({M1_ADDR, M1_DIN, M1_WE, M1_SIZE, M1_SIGN}));
    a_m1_size: assert property (@(posedge CLK) disable iff (RST)
        M1_REQ |-> size_legal(M1_SIZE));

    // IO-window loads take the same path; the data port does the redirect.
    c_io_read: cover property (@(posedge CLK) disable iff (RST)
        (state == RD_RESP) && (rd_addr_q >= IO_BASE));

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// tb/tb_otter_dmem_arbiter.sv - scoreboard bench for otter_dmem_arbiter with a synchronous-read memory model

module tb_otter_dmem_arbiter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic        sel;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    logic        m0_req, m0_we, m0_sign, m1_req, m1_we, m1_sign;
    logic [31:0] m0_addr, m0_din, m1_addr, m1_din;
    logic [1:0]  m0_size, m1_size;

    logic        a_m0_gnt, a_m0_rv, a_m1_gnt, a_m1_rv, a_wr, a_rd, a_sign;
    logic [31:0] a_m0_dout, a_m1_dout, a_addr, a_din;
    logic [1:0]  a_size;
    logic        b_m0_gnt, b_m0_rv, b_m1_gnt, b_m1_rv, b_wr, b_rd, b_sign;
    logic [31:0] b_m0_dout, b_m1_dout, b_addr, b_din;
    logic [1:0]  b_size;
    logic [31:0] mem_dout;

    // dut_a: FAIR=1, dut_b: FAIR=0 / STARVE_LIMIT=3; sel routes requests.
    otter_dmem_arbiter dut_a (
        .CLK(CLK), .RST(RST),
        .M0_REQ(m0_req & ~sel), .M0_ADDR(m0_addr), .M0_DIN(m0_din), .M0_WE(m0_we),
        .M0_SIZE(m0_size), .M0_SIGN(m0_sign), .M0_GNT(a_m0_gnt), .M0_RVALID(a_m0_rv), .M0_DOUT(a_m0_dout),
        .M1_REQ(m1_req & ~sel), .M1_ADDR(m1_addr), .M1_DIN(m1_din), .M1_WE(m1_we),
        .M1_SIZE(m1_size), .M1_SIGN(m1_sign), .M1_GNT(a_m1_gnt), .M1_RVALID(a_m1_rv), .M1_DOUT(a_m1_dout),
        .MEM_ADDR2(a_addr), .MEM_DIN2(a_din), .MEM_WRITE2(a_wr), .MEM_READ2(a_rd),
        .MEM_SIZE(a_size), .MEM_SIGN(a_sign), .MEM_DOUT2(mem_dout)
    );

    otter_dmem_arbiter #(.FAIR(1'b0), .STARVE_LIMIT(3)) dut_b (
        .CLK(CLK), .RST(RST),
        .M0_REQ(m0_req & sel), .M0_ADDR(m0_addr), .M0_DIN(m0_din), .M0_WE(m0_we),
        .M0_SIZE(m0_size), .M0_SIGN(m0_sign), .M0_GNT(b_m0_gnt), .M0_RVALID(b_m0_rv), .M0_DOUT(b_m0_dout),
        .M1_REQ(m1_req & sel), .M1_ADDR(m1_addr), .M1_DIN(m1_din), .M1_WE(m1_we),
        .M1_SIZE(m1_size), .M1_SIGN(m1_sign), .M1_GNT(b_m1_gnt), .M1_RVALID(b_m1_rv), .M1_DOUT(b_m1_dout),
        .MEM_ADDR2(b_addr), .MEM_DIN2(b_din), .MEM_WRITE2(b_wr), .MEM_READ2(b_rd),
        .MEM_SIZE(b_size), .MEM_SIGN(b_sign), .MEM_DOUT2(mem_dout)
    );

    logic        gnt0, gnt1, rv0, rv1, p_wr, p_rd, p_sign;
    logic [31:0] dout0, dout1, p_addr, p_din;
    logic [1:0]  p_size;
    assign gnt0   = sel ? b_m0_gnt  : a_m0_gnt;
    assign gnt1   = sel ? b_m1_gnt  : a_m1_gnt;
    assign rv0    = sel ? b_m0_rv   : a_m0_rv;
    assign rv1    = sel ? b_m1_rv   : a_m1_rv;
    assign dout0  = sel ? b_m0_dout : a_m0_dout;
    assign dout1  = sel ? b_m1_dout : a_m1_dout;
    assign p_addr = sel ? b_addr    : a_addr;
    assign p_din  = sel ? b_din     : a_din;
    assign p_wr   = sel ? b_wr      : a_wr;
    assign p_rd   = sel ? b_rd      : a_rd;
    assign p_size = sel ? b_size    : a_size;
    assign p_sign = sel ? b_sign    : a_sign;

    // Data-port model: synchronous read, combinational slice from live inputs.
    logic [31:0] mem [0:2047];
    logic [31:0] rd_word;
    logic        seeded = 1'b0;

    function automatic logic [10:0] midx(input logic [31:0] a);
        return {a[28], a[11:2]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        case (sz)
            2'd0:    r[8*off +: 8] = d[7:0];
            2'd1:    r[16*off[1] +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] slice(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] sz, input logic uns);
        logic [31:0] b, h;
        b = w >> (8 * off);
        h = w >> (16 * off[1]);
        case (sz)
            2'd0:    return uns ? {24'd0, b[7:0]}  : {{24{b[7]}}, b[7:0]};
            2'd1:    return uns ? {16'd0, h[15:0]} : {{16{h[15]}}, h[15:0]};
            default: return w;
        endcase
    endfunction

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!seeded) begin
            mem[midx(32'h0000_0100)] <= 32'hDEAD_BEEF;
            mem[midx(32'h0000_0204)] <= 32'h1234_5678;
            mem[midx(32'h1100_0010)] <= 32'hCAFE_F00D;
            seeded <= 1'b1;
        end else begin
            if (p_wr) mem[midx(p_addr)] <= merge(mem[midx(p_addr)], p_addr[1:0], p_size, p_din);
            if (p_rd) rd_word <= mem[midx(p_addr)];
        end
    end
    assign mem_dout = slice(rd_word, p_addr[1:0], p_size, p_sign);

    // Scoreboard
    typedef struct {
        bit          id;
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] din;
    } gexp_t;
    typedef struct {
        bit          id;
        logic [31:0] addr;
        logic [31:0] data;
    } rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_gnt(input bit id, input logic [31:0] addr, input logic we,
                           input logic [1:0] size, input logic sign, input logic [31:0] din);
        gexp_t e;
        e.id = id; e.addr = addr; e.we = we; e.size = size; e.sign = sign; e.din = din;
        gq.push_back(e);
    endtask

    task automatic exp_rd(input bit id, input logic [31:0] addr, input logic [31:0] data);
        rexp_t e;
        e.id = id; e.addr = addr; e.data = data;
        rq.push_back(e);
    endtask

    initial begin
        gexp_t g;
        rexp_t r;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (gnt0 || gnt1) begin
                    check("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
                    if (gq.size() == 0) begin
                        check("gnt_unexpected", {31'd0, gnt1}, 32'hFFFF_FFFF);
                    end else begin
                        g = gq.pop_front();
                        check("gnt_id", {31'd0, gnt1}, {31'd0, g.id});
                        check("gnt_addr", p_addr, g.addr);
                        check("gnt_write", {31'd0, p_wr}, {31'd0, g.we});
                        check("gnt_read", {31'd0, p_rd}, {31'd0, ~g.we});
                        check("gnt_size", {30'd0, p_size}, {30'd0, g.size});
                        check("gnt_sign", {31'd0, p_sign}, {31'd0, g.sign});
                        if (g.we) check("gnt_din", p_din, g.din);
                    end
                end
                if (rv0 || rv1) begin
                    check("rsp_no_gnt", {30'd0, gnt1, gnt0}, 32'd0);
                    check("rsp_no_strobe", {30'd0, p_wr, p_rd}, 32'd0);
                    if (rq.size() == 0) begin
                        check("rvalid_unexpected", {30'd0, rv1, rv0}, 32'd0);
                    end else begin
                        r = rq.pop_front();
                        check("rsp_owner", {30'd0, rv1, rv0}, r.id ? 32'd2 : 32'd1);
                        check("rsp_addr_held", p_addr, r.addr);
                        check("rsp_data", r.id ? dout1 : dout0, r.data);
                        check("rsp_other_dout", r.id ? dout0 : dout1, 32'd0);
                    end
                end
            end
        end
    end

    task automatic issue(input bit id, input logic [31:0] addr, input logic [31:0] din,
                         input logic we, input logic [1:0] size, input logic sign);
        bit got;
        got = 1'b0;
        if (id) begin
            m1_addr = addr; m1_din = din; m1_we = we; m1_size = size; m1_sign = sign; m1_req = 1'b1;
        end else begin
            m0_addr = addr; m0_din = din; m0_we = we; m0_size = size; m0_sign = sign; m0_req = 1'b1;
        end
        for (int c = 0; c < 64 && !got; c++) begin
            @(negedge CLK);
            if (!RST && (id ? gnt1 : gnt0)) got = 1'b1;
            else begin
                @(posedge CLK);
                #1;
            end
        end
        if (got) begin
            @(posedge CLK);
            #1;
        end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL grant_wait m%0d addr %h: no grant in 64 cycles, grant required", id, addr);
        end
        if (id) m1_req = 1'b0;
        else    m0_req = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 40 && (gq.size() != 0 || rq.size() != 0); c++) @(posedge CLK);
        #1;
        if (gq.size() != 0 || rq.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_%s: %0d grants / %0d reads outstanding, 0 required", tag, gq.size(), rq.size());
            gq.delete();
            rq.delete();
        end
        repeat (2) @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: still running at %0t, finish required", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        int c0;
        RST = 1'b1; sel = 1'b0;
        m0_req = 0; m0_addr = 0; m0_din = 0; m0_we = 0; m0_size = 0; m0_sign = 0;
        m1_req = 0; m1_addr = 0; m1_din = 0; m1_we = 0; m1_size = 0; m1_sign = 0;
        repeat (2) @(posedge CLK);
        #1;

        // Reset with both requesting; M0 wins the first tie after release.
        exp_gnt(0, 32'h0000_0100, 0, 2'd2, 0, 0);
        exp_gnt(1, 32'h0000_0204, 0, 2'd2, 0, 0);
        exp_rd(0, 32'h0000_0100, 32'hDEAD_BEEF);
        exp_rd(1, 32'h0000_0204, 32'h1234_5678);
        fork
            issue(0, 32'h0000_0100, 0, 0, 2'd2, 0);
            issue(1, 32'h0000_0204, 0, 0, 2'd2, 0);
            begin
                @(negedge CLK);
                check("rst_gnt", {30'd0, a_m1_gnt, a_m0_gnt}, 32'd0);
                check("rst_rvalid", {30'd0, a_m1_rv, a_m0_rv}, 32'd0);
                check("rst_strobes", {30'd0, a_wr, a_rd}, 32'd0);
                check("rst_addr", a_addr, 32'd0);
                check("rst_dout", a_m0_dout | a_m1_dout, 32'd0);
                @(posedge CLK);
                #1;
                RST = 1'b0;
                @(negedge CLK);
                check("first_gnt_m0", {30'd0, a_m1_gnt, a_m0_gnt}, 32'd1);
            end
        join
        drain("reset_load");

        // M1 byte store streaming, then read back unsigned.
        for (int i = 0; i < 3; i++) exp_gnt(1, 32'h0000_0203, 1, 2'd0, 0, 32'h0000_005A);
        c0 = cyc;
        for (int i = 0; i < 3; i++) issue(1, 32'h0000_0203, 32'h0000_005A, 1, 2'd0, 0);
        check("store_stream_cycles", cyc - c0, 32'd3);
        exp_gnt(1, 32'h0000_0203, 0, 2'd0, 1, 0);
        exp_rd(1, 32'h0000_0203, 32'h0000_005A);
        issue(1, 32'h0000_0203, 0, 0, 2'd0, 1);
        drain("store_stream");

        // Halfword store, signed and unsigned reloads, IO-range load.
        exp_gnt(0, 32'h0000_0302, 1, 2'd1, 0, 32'h0000_8001);
        exp_gnt(0, 32'h0000_0302, 0, 2'd1, 0, 0);
        exp_rd(0, 32'h0000_0302, 32'hFFFF_8001);
        exp_gnt(0, 32'h0000_0302, 0, 2'd1, 1, 0);
        exp_rd(0, 32'h0000_0302, 32'h0000_8001);
        exp_gnt(0, 32'h1100_0010, 0, 2'd2, 0, 0);
        exp_rd(0, 32'h1100_0010, 32'hCAFE_F00D);
        issue(0, 32'h0000_0302, 32'h0000_8001, 1, 2'd1, 0);
        issue(0, 32'h0000_0302, 0, 0, 2'd1, 0);
        issue(0, 32'h0000_0302, 0, 0, 2'd1, 1);
        issue(0, 32'h1100_0010, 0, 0, 2'd2, 0);
        drain("half_io");

        // Round-robin: last grant was M0, so M1 leads, then strict alternation.
        exp_gnt(1, 32'h0000_0204, 0, 2'd2, 0, 0); exp_rd(1, 32'h0000_0204, 32'h1234_5678);
        exp_gnt(0, 32'h0000_0100, 0, 2'd2, 0, 0); exp_rd(0, 32'h0000_0100, 32'hDEAD_BEEF);
        exp_gnt(1, 32'h0000_0203, 0, 2'd0, 1, 0); exp_rd(1, 32'h0000_0203, 32'h0000_005A);
        exp_gnt(0, 32'h1100_0010, 0, 2'd2, 0, 0); exp_rd(0, 32'h1100_0010, 32'hCAFE_F00D);
        exp_gnt(1, 32'h0000_0100, 0, 2'd2, 0, 0); exp_rd(1, 32'h0000_0100, 32'hDEAD_BEEF);
        exp_gnt(0, 32'h0000_0302, 0, 2'd1, 1, 0); exp_rd(0, 32'h0000_0302, 32'h0000_8001);
        c0 = cyc;
        fork
            begin
                issue(0, 32'h0000_0100, 0, 0, 2'd2, 0);
                issue(0, 32'h1100_0010, 0, 0, 2'd2, 0);
                issue(0, 32'h0000_0302, 0, 0, 2'd1, 1);
            end
            begin
                issue(1, 32'h0000_0204, 0, 0, 2'd2, 0);
                issue(1, 32'h0000_0203, 0, 0, 2'd0, 1);
                issue(1, 32'h0000_0100, 0, 0, 2'd2, 0);
            end
        join
        check("rr_cycles", cyc - c0, 32'd11);
        drain("round_robin");

        // Reset lands on the response cycle: the read is dropped.
        exp_gnt(0, 32'h0000_0100, 0, 2'd2, 0, 0);
        issue(0, 32'h0000_0100, 0, 0, 2'd2, 0);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_rvalid_n1", {31'd0, a_m0_rv}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_gnt(0, 32'h0000_0204, 0, 2'd2, 0, 0);
        exp_rd(0, 32'h0000_0204, 32'h1234_5678);
        fork
            issue(0, 32'h0000_0204, 0, 0, 2'd2, 0);
            begin
                @(negedge CLK);
                check("midrst_rvalid_n2", {31'd0, a_m0_rv}, 32'd0);
                check("midrst_idle_gnt", {31'd0, a_m0_gnt}, 32'd1);
            end
        join
        drain("mid_reset");

        // Fixed priority, STARVE_LIMIT=3: M1 wins on its 4th waiting cycle,
        // and after its count clears it again waits 4 cycles (response cycle included).
        sel = 1'b1;
        exp_gnt(0, 32'h0000_0400, 1, 2'd2, 0, 32'hA0A0_A0A0);
        exp_gnt(0, 32'h0000_0404, 1, 2'd2, 0, 32'h0000_B0B1);
        exp_gnt(0, 32'h0000_0408, 1, 2'd2, 0, 32'hC0C0_C0C0);
        exp_gnt(1, 32'h0000_0100, 0, 2'd2, 0, 0);
        exp_rd(1, 32'h0000_0100, 32'hDEAD_BEEF);
        exp_gnt(0, 32'h0000_040C, 1, 2'd2, 0, 32'hD0D0_D0D0);
        exp_gnt(0, 32'h0000_0410, 1, 2'd2, 0, 32'hE0E0_E0E0);
        exp_gnt(1, 32'h0000_0404, 0, 2'd2, 0, 0);
        exp_rd(1, 32'h0000_0404, 32'h0000_B0B1);
        exp_gnt(0, 32'h0000_0414, 1, 2'd2, 0, 32'hF0F0_F0F0);
        fork
            begin
                issue(0, 32'h0000_0400, 32'hA0A0_A0A0, 1, 2'd2, 0);
                issue(0, 32'h0000_0404, 32'h0000_B0B1, 1, 2'd2, 0);
                issue(0, 32'h0000_0408, 32'hC0C0_C0C0, 1, 2'd2, 0);
                issue(0, 32'h0000_040C, 32'hD0D0_D0D0, 1, 2'd2, 0);
                issue(0, 32'h0000_0410, 32'hE0E0_E0E0, 1, 2'd2, 0);
                issue(0, 32'h0000_0414, 32'hF0F0_F0F0, 1, 2'd2, 0);
            end
            begin
                issue(1, 32'h0000_0100, 0, 0, 2'd2, 0);
                issue(1, 32'h0000_0404, 0, 0, 2'd2, 0);
            end
        join
        drain("starve");
        sel = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/otter_dmem_arbiter.md
Name: otter_dmem_arbiter

Overview:
- Shares the OTTER memory data port (port 2) between two requesters: M0 = CPU load/store unit, M1 = loader/DMA engine (e.g. UART program loader).
- Sits directly in front of the data port. Drives its address, write-data, write, read, size and sign inputs, and returns sliced read data to the owning requester.
- Sequences the port's synchronous-read timing. Read data appears the cycle after MEM_READ2 and is sliced combinationally from the live address, size and sign, so those must be held through the response cycle.

Parameters:
- FAIR, 1: 1 = round-robin between M0/M1; 0 = fixed M0 priority with starvation guard.
- STARVE_LIMIT, 8: with FAIR=0, number of cycles M1 may wait with REQ high before it wins the next arbitration. Must be ≥1.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous, active-high reset
- M0_REQ  in  1  CPU request; fields held stable until M0_GNT
- M0_ADDR  in  32  byte address
- M0_DIN  in  32  store data
- M0_WE  in  1  1 = store, 0 = load
- M0_SIZE  in  2  0 byte, 1 half, 2 word
- M0_SIGN  in  1  1 = unsigned load
- M0_GNT  out  1  request accepted this cycle (combinational)
- M0_RVALID  out  1  M0_DOUT valid this cycle
- M0_DOUT  out  32  load data
- M1_REQ, M1_ADDR, M1_DIN, M1_WE, M1_SIZE, M1_SIGN, M1_GNT, M1_RVALID, M1_DOUT: same as M0 set, for requester 1
- MEM_ADDR2  out  32  to data port
- MEM_DIN2  out  32  to data port
- MEM_WRITE2  out  1  to data port
- MEM_READ2  out  1  to data port
- MEM_SIZE  out  2  to data port
- MEM_SIGN  out  1  to data port
- MEM_DOUT2  in  32  sliced read data from data port

Behaviour:
- Clock/reset: single clock CLK; RST synchronous, active-high.
- Reset values:
  - state = IDLE, last_grant = M1 (so M0 wins first tie), starve_cnt = 0.
  - All GNT/RVALID = 0; MEM_WRITE2 = MEM_READ2 = 0.
  - MEM_ADDR2/DIN2/SIZE/SIGN = 0; M*_DOUT = 0.
- State IDLE:
  - Pick a winner among asserted REQs and assert its GNT combinationally.
  - Drive the winner's ADDR/DIN/SIZE/SIGN to the port.
  - Store: MEM_WRITE2 = 1, stay IDLE. Zero-wait, so back-to-back stores are accepted every cycle.
  - Load: MEM_READ2 = 1, capture owner and fields into registers, go to RD_RESP.
  - No REQ: all port strobes 0, fields 0.
- State RD_RESP (exactly 1 cycle):
  - Drive the registered ADDR/SIZE/SIGN; MEM_READ2 = 0, MEM_WRITE2 = 0.
  - Owner's RVALID = 1, owner's DOUT = MEM_DOUT2; non-owner DOUT = 0.
  - No GNT in this cycle. Return to IDLE.
  - Load latency: GNT at cycle N, RVALID/DOUT at cycle N+1. Next grant earliest at N+2.
- Arbitration with FAIR=1:
  - On a tie, grant the requester other than last_grant.
  - last_grant updates on every grant.
- Arbitration with FAIR=0:
  - M0 wins ties unless starve_cnt == STARVE_LIMIT, in which case M1 wins.
  - starve_cnt increments (saturating at STARVE_LIMIT) every cycle M1_REQ = 1 and M1_GNT = 0, including RD_RESP cycles.
  - starve_cnt clears on M1_GNT or when M1_REQ = 0.
- A lone requester is always granted in IDLE regardless of FAIR.
- Requester rules (checked by assertion):
  - REQ is not dropped before GNT.
  - Fields are stable while REQ is high and GNT is low.
  - Requester may re-request in the cycle after GNT.
- IO range: addresses ≥ 0x11000000 pass through unchanged; the data port redirects them internally. Arbiter timing is identical for IO.
- Reset during RD_RESP: next state IDLE, pending read dropped, no RVALID issued.
- RST has priority over all requests.

Decomposition:
- Package otter_dmem_arb_pkg:
  - state enum {IDLE, RD_RESP}
  - requester-id typedef (M0 = 0, M1 = 1)
  - size constants SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2
  - IO_BASE = 32'h11000000
- Sub-module otter_arb2_picker: 2-way winner selection, holding last_grant and starve_cnt. Inputs: req[1:0], grant_accept, FAIR/STARVE_LIMIT parameters. Outputs: winner id and valid.
- Top module holds the FSM, request capture registers and port muxing.

Test Plan:
- Reset: RST = 1 with both REQ high → all GNT/RVALID, MEM_WRITE2 and MEM_READ2 = 0. First cycle after RST low: M0_GNT = 1.
- CPU load: M0 lw at 0x100 holding 0xDEADBEEF → GNT at cycle N; MEM_ADDR2 = 0x100 in cycles N and N+1; M0_RVALID = 1, M0_DOUT = 0xDEADBEEF at N+1; M1_RVALID = 0.
- Store streaming: M1 sb to 0x203 with DIN = 0x5A in 3 consecutive cycles → GNT every cycle, MEM_WRITE2 = 1 ×3, MEM_SIZE = 0. A following lbu from 0x203 returns 0x0000005A.
- Round-robin (FAIR=1): both requesters issue continuous loads → grants alternate M0, M1, M0, M1 every 2 cycles. Each RVALID reaches the correct owner.
- Starvation (FAIR=0, STARVE_LIMIT=3): M0 issues continuous stores and M1 holds a load request → M1_GNT on the 4th cycle of waiting, then starve_cnt = 0.
- Mid-read reset: M0 load granted at N, RST = 1 at N+1 → M0_RVALID stays 0 at N+1 and N+2, state IDLE. The next M0 load completes normally.
